// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath enables and selects.
module mc_ctrl #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [3:0]       aluop,
  output logic             ext,
  output logic             s_b,
  output logic [1:0]       s_num_write,
  output logic [1:0]       s_data_write,
  output logic [1:0]       s_npc,
  output logic [4:0]       s_shamt_id,
  output logic             instr_done,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic              err_nxt;

  logic       is_rtype, is_j, is_jal, is_jr, is_beq, is_lw, is_sw;
  logic       dec_known, dec_ext, dec_s_b;
  logic [3:0] dec_alu;
  logic [4:0] dec_shamt;

  logic       ready_c, timeout_c;
  logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
  logic [3:0] aluop_c;
  logic       ext_c, s_b_c, done_c, illegal_c;
  logic [1:0] s_num_c, s_data_c, s_npc_c;
  logic [4:0] s_shamt_c;

  // Instruction decode from the IR; op/funct stay stable from DECODE to retire.
  always_comb begin : decode
    is_rtype  = (op == OP_RTYPE);
    is_jr     = is_rtype && (funct == FN_JR);
    is_j      = (op == OP_J);
    is_jal    = (op == OP_JAL);
    is_beq    = (op == OP_BEQ);
    is_lw     = (op == OP_LW);
    is_sw     = (op == OP_SW);
    dec_known = 1'b1;
    dec_alu   = ALU_ADD;
    dec_ext   = 1'b0;
    dec_s_b   = 1'b0;
    dec_shamt = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: dec_alu = ALU_ADD;
          FN_SUBU: dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_XOR:  dec_alu = ALU_XOR;
          FN_NOR:  dec_alu = ALU_NOR;
          FN_SLT:  dec_alu = ALU_SLT;
          FN_SLL: begin
            dec_alu   = ALU_SLL;
            dec_shamt = shamt;
          end
          FN_JR:   dec_alu = ALU_ADD;
          default: dec_known = 1'b0;
        endcase
      end
      OP_J, OP_JAL: dec_alu = ALU_ADD;
      OP_BEQ: begin
        dec_alu = ALU_SUB;
        dec_ext = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        dec_alu = ALU_ADD;
        dec_ext = 1'b1;
        dec_s_b = 1'b1;
      end
      OP_ANDI: begin
        dec_alu = ALU_AND;
        dec_s_b = 1'b1;
      end
      OP_ORI: begin
        dec_alu = ALU_OR;
        dec_s_b = 1'b1;
      end
      OP_LUI: begin
        dec_alu = ALU_LUI;
        dec_s_b = 1'b1;
      end
      default: dec_known = 1'b0;
    endcase
  end

  assign ready_c   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign wait_inc  = wait_cnt + WAIT_W'(1);
  assign timeout_c = (wait_inc == WAIT_MAX);

  // Next state and per-state datapath controls.
  always_comb begin : fsm_next
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    err_nxt     = err;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    aluop_c     = '0;
    ext_c       = 1'b0;
    s_b_c       = 1'b0;
    s_num_c     = 2'b00;
    s_data_c    = 2'b00;
    s_npc_c     = 2'b11;
    s_shamt_c   = '0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (ready_c) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end else if (timeout_c) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      S_DECODE: begin
        if (!dec_known) begin
          illegal_c = 1'b1;
          done_c    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_j || is_jal) begin
          pc_write_c = 1'b1;
          s_npc_c    = 2'b10;
          done_c     = 1'b1;
          state_nxt  = S_FETCH;
          if (is_jal) begin
            reg_write_c = 1'b1;
            s_num_c     = 2'b10;
            s_data_c    = 2'b00;
          end
        end else if (is_jr) begin
          pc_write_c = 1'b1;
          s_npc_c    = 2'b01;
          done_c     = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        aluop_c   = dec_alu;
        ext_c     = dec_ext;
        s_b_c     = dec_s_b;
        s_shamt_c = dec_shamt;
        if (is_beq) begin
          pc_write_c = alu_zero;
          s_npc_c    = 2'b00;
          done_c     = 1'b1;
          state_nxt  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        // Address selects held so the ALU result stays valid across waits.
        aluop_c     = dec_alu;
        ext_c       = dec_ext;
        s_b_c       = dec_s_b;
        s_shamt_c   = dec_shamt;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (ready_c) begin
          if (is_lw) begin
            state_nxt = S_WB;
          end else begin
            done_c    = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (timeout_c) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        s_num_c     = is_rtype ? 2'b01 : 2'b00;
        s_data_c    = is_lw ? 2'b10 : 2'b01;
        done_c      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_FETCH;
    endcase
    if (state_nxt != state) wait_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err      <= err_nxt;
      if (done_c) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // FETCH is also the reset state; its requests stay low while rst_n is held.
  assign pc_write     = pc_write_c & rst_n;
  assign ir_write     = ir_write_c & rst_n;
  assign mem_read     = mem_read_c & rst_n;
  assign mem_write    = mem_write_c;
  assign reg_write    = reg_write_c;
  assign aluop        = aluop_c;
  assign ext          = ext_c;
  assign s_b          = s_b_c;
  assign s_num_write  = s_num_c;
  assign s_data_write = s_data_c;
  assign s_npc        = s_npc_c;
  assign s_shamt_id   = s_shamt_c;
  assign instr_done   = done_c;
  assign illegal      = illegal_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-cycle output bundles and retire latency
// are predicted from an ISA table and the per-class phase sequence.
module tb_mc_ctrl;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLL = 4'd8,
                         A_LUI = 4'd11;

  typedef enum int {C_J, C_JR, C_JAL, C_ILL, C_BEQ, C_RALU, C_IALU, C_LW, C_SW} cls_e;
  typedef enum int {P_RST, P_F, P_D, P_E, P_M, P_W, P_ERR} ph_e;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    bit         ffix;
    cls_e       cls;
    logic [3:0] alu;
    bit         ext;
    bit         imm;
    bit         sll;
  } ins_t;

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [3:0] aluop;
    logic       ext, s_b;
    logic [1:0] s_num_write, s_data_write, s_npc;
    logic [4:0] s_shamt_id;
    logic       instr_done, illegal, err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n, alu_zero, mem_ready;
  logic [5:0] op, funct;
  logic [4:0] shamt;

  logic pc_write, ir_write, mem_read, mem_write, reg_write, ext, s_b, instr_done, illegal, err;
  logic [3:0] aluop;
  logic [1:0] s_num_write, s_data_write, s_npc;
  logic [4:0] s_shamt_id;
  logic [31:0] instr_cnt;

  logic pc_write_n, ir_write_n, mem_read_n, mem_write_n, reg_write_n, ext_n, s_b_n;
  logic instr_done_n, illegal_n, err_n;
  logic [3:0] aluop_n;
  logic [1:0] s_num_write_n, s_data_write_n, s_npc_n;
  logic [4:0] s_shamt_id_n;
  logic [31:0] instr_cnt_n;

  outs_t obs_m, obs_n;
  ins_t  tbl[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc_n, done_at;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .shamt(shamt),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .aluop(aluop), .ext(ext),
    .s_b(s_b), .s_num_write(s_num_write), .s_data_write(s_data_write),
    .s_npc(s_npc), .s_shamt_id(s_shamt_id), .instr_done(instr_done),
    .illegal(illegal), .err(err), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.MEM_WAIT_EN(1'b0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .shamt(shamt),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .ir_write(ir_write_n), .mem_read(mem_read_n),
    .mem_write(mem_write_n), .reg_write(reg_write_n), .aluop(aluop_n), .ext(ext_n),
    .s_b(s_b_n), .s_num_write(s_num_write_n), .s_data_write(s_data_write_n),
    .s_npc(s_npc_n), .s_shamt_id(s_shamt_id_n), .instr_done(instr_done_n),
    .illegal(illegal_n), .err(err_n), .instr_cnt(instr_cnt_n)
  );

  assign obs_m = {pc_write, ir_write, mem_read, mem_write, reg_write, aluop, ext, s_b,
                  s_num_write, s_data_write, s_npc, s_shamt_id, instr_done, illegal, err};
  assign obs_n = {pc_write_n, ir_write_n, mem_read_n, mem_write_n, reg_write_n, aluop_n,
                  ext_n, s_b_n, s_num_write_n, s_data_write_n, s_npc_n, s_shamt_id_n,
                  instr_done_n, illegal_n, err_n};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void add(input string n, input logic [5:0] o, input logic [5:0] f,
                              input bit ff, input cls_e c, input logic [3:0] a,
                              input bit e, input bit i, input bit s);
    ins_t t;
    t.name = n; t.op = o; t.funct = f; t.ffix = ff; t.cls = c;
    t.alu = a; t.ext = e; t.imm = i; t.sll = s;
    tbl.push_back(t);
  endfunction

  function automatic int find(input string n);
    foreach (tbl[k]) if (tbl[k].name == n) return k;
    return 0;
  endfunction

  function automatic int base_lat(input cls_e c);
    case (c)
      C_BEQ:               return 3;
      C_RALU, C_IALU, C_SW: return 4;
      C_LW:                return 5;
      default:             return 2;
    endcase
  endfunction

  // Expected output bundle for one cycle of a given phase.
  function automatic outs_t exp_out(input ph_e ph, input ins_t in, input bit rdy,
                                    input bit z, input logic [4:0] sh);
    outs_t e;
    e = '0;
    e.s_npc = 2'b11;
    case (ph)
      P_F: begin
        e.mem_read = 1'b1;
        e.ir_write = rdy;
        e.pc_write = rdy;
      end
      P_D: begin
        case (in.cls)
          C_J:   begin e.pc_write = 1'b1; e.s_npc = 2'b10; e.instr_done = 1'b1; end
          C_JAL: begin
            e.pc_write = 1'b1; e.s_npc = 2'b10; e.instr_done = 1'b1;
            e.reg_write = 1'b1; e.s_num_write = 2'b10; e.s_data_write = 2'b00;
          end
          C_JR:  begin e.pc_write = 1'b1; e.s_npc = 2'b01; e.instr_done = 1'b1; end
          C_ILL: begin e.illegal = 1'b1; e.instr_done = 1'b1; end
          default: ;
        endcase
      end
      P_E, P_M: begin
        e.aluop = in.alu;
        e.ext = in.ext;
        e.s_b = in.imm;
        e.s_shamt_id = in.sll ? sh : 5'd0;
        if (ph == P_E && in.cls == C_BEQ) begin
          e.pc_write = z; e.s_npc = 2'b00; e.instr_done = 1'b1;
        end
        if (ph == P_M) begin
          e.mem_read = (in.cls == C_LW);
          e.mem_write = (in.cls == C_SW);
          e.instr_done = (in.cls == C_SW) && rdy;
        end
      end
      P_W: begin
        e.reg_write = 1'b1;
        e.s_num_write = (in.cls == C_RALU) ? 2'b01 : 2'b00;
        e.s_data_write = (in.cls == C_LW) ? 2'b10 : 2'b01;
        e.instr_done = 1'b1;
      end
      P_ERR: e.err = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input string tag, input outs_t e, input bit nw);
    outs_t o;
    @(negedge clk);
    o = nw ? obs_n : obs_m;
    check_eq(tag, 32'(o), 32'(e));
    cyc_n++;
    if (o.instr_done && done_at < 0) done_at = cyc_n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ins_t none;
    #1 rst_n = 1'b0;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    none = tbl[0];
    @(negedge clk);
    check_eq("reset_out", 32'(obs_m), 32'(exp_out(P_RST, none, 1'b0, 1'b0, 5'd0)));
    check_eq("reset_out_nw", 32'(obs_n), 32'(exp_out(P_RST, none, 1'b0, 1'b0, 5'd0)));
    check_eq("reset_cnt", instr_cnt, 32'd0);
    check_eq("reset_cnt_nw", instr_cnt_n, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  // Run one instruction from FETCH to retire; negative arguments pick randomly.
  task automatic run_instr(input int idx, input bit nw, input int fwait, input int mwait,
                           input int zero);
    ins_t in;
    int fw, mw, lat;
    bit z, rdy;
    logic [4:0] sh;
    in = tbl[idx];
    fw = (fwait < 0) ? int'($urandom_range(0, 3)) : fwait;
    mw = (mwait < 0) ? int'($urandom_range(0, 3)) : mwait;
    z  = (zero < 0) ? 1'($urandom_range(0, 1)) : (zero != 0);
    sh = 5'($urandom);
    op = in.op;
    funct = in.ffix ? in.funct : 6'($urandom);
    shamt = sh;
    alu_zero = 1'($urandom);
    cyc_n = 0;
    done_at = -1;
    for (int w = 0; w <= fw; w++) begin
      mem_ready = (w == fw);
      rdy = nw || mem_ready;
      step({in.name, ":F"}, exp_out(P_F, in, rdy, z, sh), nw);
      if (rdy) break;
    end
    mem_ready = 1'($urandom);
    step({in.name, ":D"}, exp_out(P_D, in, 1'b0, z, sh), nw);
    if (in.cls inside {C_BEQ, C_RALU, C_IALU, C_LW, C_SW}) begin
      alu_zero = z;
      mem_ready = 1'($urandom);
      step({in.name, ":E"}, exp_out(P_E, in, 1'b0, z, sh), nw);
      alu_zero = 1'($urandom);
      if (in.cls inside {C_LW, C_SW}) begin
        for (int w = 0; w <= mw; w++) begin
          mem_ready = (w == mw);
          rdy = nw || mem_ready;
          step({in.name, ":M"}, exp_out(P_M, in, rdy, z, sh), nw);
          if (rdy) break;
        end
      end
      if (in.cls inside {C_RALU, C_IALU, C_LW}) begin
        mem_ready = 1'($urandom);
        step({in.name, ":W"}, exp_out(P_W, in, 1'b0, z, sh), nw);
      end
    end
    exp_cnt++;
    lat = base_lat(in.cls) + (nw ? 0 : fw) + ((!nw && in.cls inside {C_LW, C_SW}) ? mw : 0);
    check_eq({in.name, ":latency"}, 32'(done_at), 32'(lat));
    check_eq({in.name, ":instr_cnt"}, nw ? instr_cnt_n : instr_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins_t in;
    rst_n = 1'b1; op = '0; funct = '0; shamt = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    add("ADDU", 6'h00, 6'h21, 1, C_RALU, A_ADD, 0, 0, 0);
    add("SUBU", 6'h00, 6'h23, 1, C_RALU, A_SUB, 0, 0, 0);
    add("AND",  6'h00, 6'h24, 1, C_RALU, A_AND, 0, 0, 0);
    add("OR",   6'h00, 6'h25, 1, C_RALU, A_OR,  0, 0, 0);
    add("XOR",  6'h00, 6'h26, 1, C_RALU, A_XOR, 0, 0, 0);
    add("NOR",  6'h00, 6'h27, 1, C_RALU, A_NOR, 0, 0, 0);
    add("SLT",  6'h00, 6'h2A, 1, C_RALU, A_SLT, 0, 0, 0);
    add("SLL",  6'h00, 6'h00, 1, C_RALU, A_SLL, 0, 0, 1);
    add("JR",   6'h00, 6'h08, 1, C_JR,   A_ADD, 0, 0, 0);
    add("SRL",  6'h00, 6'h02, 1, C_ILL,  A_ADD, 0, 0, 0);
    add("BADFN",6'h00, 6'h3F, 1, C_ILL,  A_ADD, 0, 0, 0);
    add("J",    6'h02, 6'h00, 0, C_J,    A_ADD, 0, 0, 0);
    add("JAL",  6'h03, 6'h00, 0, C_JAL,  A_ADD, 0, 0, 0);
    add("BEQ",  6'h04, 6'h00, 0, C_BEQ,  A_SUB, 1, 0, 0);
    add("ADDI", 6'h08, 6'h00, 0, C_IALU, A_ADD, 1, 1, 0);
    add("ADDIU",6'h09, 6'h00, 0, C_IALU, A_ADD, 1, 1, 0);
    add("ANDI", 6'h0C, 6'h00, 0, C_IALU, A_AND, 0, 1, 0);
    add("ORI",  6'h0D, 6'h00, 0, C_IALU, A_OR,  0, 1, 0);
    add("LUI",  6'h0F, 6'h00, 0, C_IALU, A_LUI, 0, 1, 0);
    add("LW",   6'h23, 6'h00, 0, C_LW,   A_ADD, 1, 1, 0);
    add("SW",   6'h2B, 6'h00, 0, C_SW,   A_ADD, 1, 1, 0);
    add("BADOP",6'h3F, 6'h00, 0, C_ILL,  A_ADD, 0, 0, 0);
    add("BNE",  6'h05, 6'h00, 0, C_ILL,  A_ADD, 0, 0, 0);

    do_reset();
    run_instr(find("ADDU"), 0, 0, 0, 0);
    run_instr(find("LW"), 0, 0, 3, 0);
    run_instr(find("BEQ"), 0, 0, 0, 1);
    run_instr(find("BEQ"), 0, 0, 0, 0);
    run_instr(find("JAL"), 0, 0, 0, 0);
    run_instr(find("BADOP"), 0, 0, 0, 0);
    run_instr(find("ADDU"), 0, 14, 0, 0);
    run_instr(find("SW"), 0, 0, 14, 0);
    for (int k = 0; k < 60; k++)
      run_instr(int'($urandom_range(0, tbl.size() - 1)), 0, -1, -1, -1);

    // Memory never answers in FETCH: 15 waiting cycles, then a sticky error.
    in = tbl[find("ADDU")];
    op = in.op; funct = in.funct; mem_ready = 1'b0;
    for (int w = 0; w < 15; w++) step("timeout:F", exp_out(P_F, in, 1'b0, 1'b0, 5'd0), 0);
    for (int w = 0; w < 3; w++) begin
      mem_ready = 1'($urandom);
      step("timeout:ERR", exp_out(P_ERR, in, 1'b0, 1'b0, 5'd0), 0);
    end
    check_eq("timeout:cnt", instr_cnt, exp_cnt);
    #1 rst_n = 1'b0;
    #1;
    check_eq("timeout:reset", 32'(obs_m), 32'(exp_out(P_RST, in, 1'b0, 1'b0, 5'd0)));
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    run_instr(find("ADDU"), 0, 0, 0, 0);

    do_reset();
    run_instr(find("SW"), 1, 3, 5, 0);
    for (int k = 0; k < 20; k++)
      run_instr(int'($urandom_range(0, tbl.size() - 1)), 1, -1, -1, -1);

    // Reset lands while SW is waiting in MEM.
    do_reset();
    in = tbl[find("SW")];
    op = in.op; funct = 6'($urandom); shamt = 5'($urandom);
    cyc_n = 0; done_at = -1;
    mem_ready = 1'b1;
    step("rst_sw:F", exp_out(P_F, in, 1'b1, 1'b0, shamt), 0);
    mem_ready = 1'b0;
    step("rst_sw:D", exp_out(P_D, in, 1'b0, 1'b0, shamt), 0);
    step("rst_sw:E", exp_out(P_E, in, 1'b0, 1'b0, shamt), 0);
    step("rst_sw:M", exp_out(P_M, in, 1'b0, 1'b0, shamt), 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_sw:drop", 32'(obs_m), 32'(exp_out(P_RST, in, 1'b0, 1'b0, 5'd0)));
    check_eq("rst_sw:cnt", instr_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    run_instr(find("SW"), 0, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath enables plus the existing mux selects.
- Holds in FETCH and MEM while memory is not ready, flags memory timeouts and illegal opcodes, and counts retired instructions.
- Sits between the IR (op/funct/shamt) and the shared PC/regfile/ALU/memory datapath.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = memory is treated as always ready.
- WAIT_W, 4: width of the memory-wait counter. Timeout occurs at 2^WAIT_W-1 waiting cycles.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- shamt  in  5  IR[10:6].
- alu_zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  regfile write enable.
- aluop  out  4  ALU operation, using the header.v codes.
- ext  out  1  1 = sign-extend imm16.
- s_b  out  1  1 = ALU B input is the immediate.
- s_num_write  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- s_data_write  out  2  write-data select: 00 PC+4, 01 ALU, 10 memory.
- s_npc  out  2  next-PC select: 00 branch, 01 rs (JR), 10 jump target, 11 PC+4.
- s_shamt_id  out  5  shamt for SLL, else 0.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse in DECODE on an unknown op/funct.
- err  out  1  sticky memory-timeout flag.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERR (binary encoding). Reset enters FETCH.
- Reset values: every output 0, except s_npc = 11. instr_cnt = 0. Wait counter = 0.
- FETCH:
  - Asserts mem_read with s_npc = 11.
  - On a ready cycle (mem_ready, or always when MEM_WAIT_EN = 0): pulse ir_write and pc_write, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - J: pc_write, s_npc = 10, retire, go to FETCH.
  - JR (op 0, funct 001000): pc_write, s_npc = 01, retire, go to FETCH.
  - JAL: pc_write, s_npc = 10, reg_write, s_num_write = 10, s_data_write = 00, retire, go to FETCH.
  - Unknown op, or R-type with an unknown funct: pulse illegal, retire, go to FETCH.
  - All other instructions: go to EXEC.
- EXEC: aluop, ext, s_b and s_shamt_id are driven as in the single-cycle decode.
  - R-type ALU ops and ADDI/ADDIU/ANDI/ORI/LUI go to WB.
  - LW and SW go to MEM.
  - BEQ: pc_write = alu_zero, with s_npc = 00; retire; go to FETCH.
- MEM:
  - LW asserts mem_read; SW asserts mem_write.
  - Hold the ALU selects stable until ready, using the same wait rules as FETCH.
  - On ready: LW goes to WB; SW retires and goes to FETCH.
- WB:
  - reg_write = 1 for one cycle.
  - s_num_write = 01 for R-type, 00 otherwise.
  - s_data_write = 10 for LW, 01 otherwise.
  - Retire, go to FETCH.
- Retire:
  - Pulse instr_done and increment instr_cnt by 1.
  - instr_cnt wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on every state change.
  - Saturation (all ones) while still not ready: go to ERR and set err. No retire.
  - Not used when MEM_WAIT_EN = 0.
- ERR: all enables 0. The state is held until rst_n is asserted; err stays 1.
- Outputs not named for a state are 0 in that state. s_npc defaults to 11.
- mem_ready arriving on the same edge the counter would saturate counts as ready; there is no error.
- Reset asserted mid-instruction: asynchronous return to FETCH with all enables dropped. No partial writes occur after reset asserts.
- Per-class latencies, with zero wait states:
  - J, JR, JAL, illegal: 2 cycles.
  - BEQ: 3 cycles.
  - R-type, I-type ALU, SW: 4 cycles.
  - LW: 5 cycles.

Test Plan:
- ADDU (op 0, funct 100001), mem_ready = 1:
  - States F, D, E, W.
  - reg_write only in the 4th cycle, with s_num_write = 01 and s_data_write = 01.
  - instr_done pulses; instr_cnt goes 0 -> 1.
- LW (op 100011), mem_ready low for 3 MEM cycles:
  - Stays in MEM for 4 cycles, then WB with s_data_write = 10.
  - Total 8 cycles; err = 0.
- BEQ (op 000100) with alu_zero = 1, then again with alu_zero = 0:
  - pc_write = 1 with s_npc = 00 in EXEC for the first.
  - pc_write = 0 in EXEC for the second.
  - Both take 3 cycles.
- JAL (op 000011):
  - In DECODE: pc_write = 1, reg_write = 1, s_num_write = 10, s_data_write = 00, s_npc = 10.
  - Next cycle is FETCH.
- Timeout: WAIT_W = 4 and mem_ready held 0 in FETCH.
  - ERR is entered after 15 waiting cycles; err = 1 and stays set.
  - rst_n = 0 clears err and returns the FSM to FETCH.
- Edge cases:
  - op 111111 gives an illegal pulse in DECODE; instr_cnt still increments.
  - MEM_WAIT_EN = 0 ignores mem_ready = 0; SW completes in 4 cycles.
  - Asserting rst_n = 0 during MEM of SW drops mem_write immediately.
